// File: rtl/alu_sequencer.sv
// alu_sequencer: in-order command queue that sequences one op at a time through the shared ALU.
// Latency: push to ISSUE >= 2 cycles from IDLE; result valid ALU_LAT+1 cycles after the issue cycle.
// Backpressure: cmd_ready drops only when the FIFO is full; res_* held until res_ready handshake.
// Optional statistics outputs (stat_ops, stat_stall) are built when ALU_SEQ_STATS_EN is defined.
module alu_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_kind,
  input  logic [2:0]       cmd_opselect,
  input  logic [2:0]       cmd_operation,
  input  logic [4:0]       cmd_shamt,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_in1,
  output logic [31:0]      alu_in2,
  output logic [2:0]       alu_opselect,
  output logic [2:0]       alu_operation,
  output logic [4:0]       alu_shift_number,
  output logic             alu_enable_arith,
  output logic             alu_enable_shift,
  input  logic [31:0]      alu_out,
  input  logic             alu_carryout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_carry,
  output logic [TAG_W-1:0] res_tag
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_stall
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(ALU_LAT + 1);

  // One queued command; also the shape of the held copy that keeps ALU inputs stable in WAIT.
  typedef struct packed {
    logic             kind;
    logic [2:0]       opselect;
    logic [2:0]       operation;
    logic [4:0]       shamt;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          push_cmd;
  cmd_t          head;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  cmd_t          hold;
  cmd_t          drive;
  logic          last_wait;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  // The head leaves the queue in the single cycle it is presented to the ALU.
  assign pop       = (state == ISSUE);
  assign head      = mem[rd_ptr];
  assign last_wait = (state == WAIT) && (cnt == CW'(1));
  assign res_valid = (state == DONE);

  assign push_cmd.kind      = cmd_kind;
  assign push_cmd.opselect  = cmd_opselect;
  assign push_cmd.operation = cmd_operation;
  assign push_cmd.shamt     = cmd_shamt;
  assign push_cmd.a         = cmd_a;
  assign push_cmd.b         = cmd_b;
  assign push_cmd.tag       = cmd_tag;

  // FIFO storage; stale entries behind the pointers are never read, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_cmd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, ALU enables and the source of the ALU operand/opcode outputs.
  always_comb begin
    state_nxt        = state;
    alu_enable_arith = 1'b0;
    alu_enable_shift = 1'b0;
    drive            = hold;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        drive            = head;
        alu_enable_arith = !head.kind;
        alu_enable_shift = head.kind;
        state_nxt        = WAIT;
      end
      WAIT: begin
        if (last_wait) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Back-to-back issue on the accepting edge when more work is queued.
        if (res_ready) begin
          state_nxt = empty ? IDLE : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign alu_in1          = drive.a;
  assign alu_in2          = drive.b;
  assign alu_opselect     = drive.opselect;
  assign alu_operation    = drive.operation;
  assign alu_shift_number = drive.shamt;

  // Issue capture, latency countdown and result capture at the end of the last WAIT cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold      <= '0;
      cnt       <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_tag   <= '0;
    end else begin
      if (state == ISSUE) begin
        hold <= head;
        cnt  <= CW'(ALU_LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
      if (last_wait) begin
        res_data  <= alu_out;
        res_carry <= alu_carryout;
        res_tag   <= hold.tag;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Completed-result counter (wraps) and consumer-stall counter (saturates).
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (res_valid && res_ready) begin
        stat_ops <= stat_ops + 16'd1;
      end
      if (res_valid && !res_ready && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule
